// File: rtl/delay_calibrator.sv
// delay_calibrator: averages each channel's rising-edge offset from channel 0 and publishes
// per-channel delays that align all channels. Define DLYCAL_ROUND_EN to round averages half up.
module delay_calibrator #(
  parameter int NCHAN   = 4,
  parameter int NBITS   = 4,
  parameter int LOG2N   = 3,
  parameter int MAXMISS = 15
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [NCHAN-1:0] Channels,
  output logic [NBITS-1:0] Delays [NCHAN-1:0],
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [NBITS-1:0] MissCnt
);

  localparam int ACCW = NBITS + LOG2N;
  localparam int EVW  = LOG2N + 1;
  localparam logic [NBITS-1:0] CNT_MAX  = '1;
  localparam logic [EVW-1:0]   NEVENTS  = EVW'(1) << LOG2N;
  localparam logic [NBITS-1:0] MISS_LIM = NBITS'(MAXMISS);
`ifdef DLYCAL_ROUND_EN
  localparam logic [ACCW:0]    HALF     = (ACCW+1)'(1) << (LOG2N-1);
`endif

  typedef enum logic [2:0] {IDLE, ARM, WINDOW, ACCUM, COMPUTE} state_e;

  state_e           state_q, state_d;
  logic [NCHAN-1:0] prev_q;
  logic [NCHAN-1:0] chEdge;
  logic [NCHAN-1:0] hit_q, hit_d;
  logic [NCHAN-1:0] newHit;
  logic [NBITS-1:0] off_q [NCHAN-1:0];
  logic [NBITS-1:0] off_d [NCHAN-1:0];
  logic [ACCW-1:0]  acc_q [NCHAN-1:0];
  logic [ACCW-1:0]  acc_d [NCHAN-1:0];
  logic [NBITS-1:0] dly_q [NCHAN-1:0];
  logic [NBITS-1:0] dly_d [NCHAN-1:0];
  logic [NBITS-1:0] avg   [NCHAN-1:0];
  logic [NBITS-1:0] maxAvg;
  logic [EVW-1:0]   evCnt_q, evCnt_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] missCnt_q, missCnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  assign chEdge = Channels & ~prev_q;

  // Averages can never exceed the largest offset, so NBITS always holds the result.
  always_comb begin
    maxAvg = '0;
    for (int i = 0; i < NCHAN; i++) begin
`ifdef DLYCAL_ROUND_EN
      avg[i] = NBITS'(({1'b0, acc_q[i]} + HALF) >> LOG2N);
`else
      avg[i] = NBITS'(acc_q[i] >> LOG2N);
`endif
      if (avg[i] > maxAvg) maxAvg = avg[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    hit_d     = hit_q;
    off_d     = off_q;
    acc_d     = acc_q;
    dly_d     = dly_q;
    evCnt_d   = evCnt_q;
    cnt_d     = cnt_q;
    missCnt_d = missCnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    newHit    = '0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          for (int i = 0; i < NCHAN; i++) acc_d[i] = '0;
          evCnt_d   = '0;
          missCnt_d = '0;
          err_d     = 1'b0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (chEdge[0]) begin
          hit_d = chEdge;
          for (int i = 0; i < NCHAN; i++) off_d[i] = '0;
          cnt_d   = NBITS'(1);
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        // Only the first edge of each channel within an event is kept.
        newHit    = chEdge & ~hit_q;
        newHit[0] = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
          if (newHit[i]) off_d[i] = cnt_q;
        end
        hit_d = hit_q | newHit;
        if ((&hit_d) || (cnt_q == CNT_MAX)) state_d = ACCUM;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      ACCUM: begin
        if (&hit_q) begin
          for (int i = 0; i < NCHAN; i++) acc_d[i] = acc_q[i] + ACCW'(off_q[i]);
          evCnt_d = evCnt_q + 1'b1;
          state_d = (evCnt_d == NEVENTS) ? COMPUTE : ARM;
        end else begin
          missCnt_d = missCnt_q + 1'b1;
          if (missCnt_d == MISS_LIM) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ARM;
          end
        end
      end
      COMPUTE: begin
        for (int i = 0; i < NCHAN; i++) dly_d[i] = maxAvg - avg[i];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev_q    <= '0;
      hit_q     <= '0;
      evCnt_q   <= '0;
      cnt_q     <= '0;
      missCnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        off_q[i] <= '0;
        acc_q[i] <= '0;
        dly_q[i] <= '0;
      end
    end else begin
      prev_q    <= Channels;
      hit_q     <= hit_d;
      evCnt_q   <= evCnt_d;
      cnt_q     <= cnt_d;
      missCnt_q <= missCnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      off_q     <= off_d;
      acc_q     <= acc_d;
      dly_q     <= dly_d;
    end
  end

  assign Delays  = dly_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Err     = err_q;
  assign MissCnt = missCnt_q;

endmodule

// File: tb/tb_delay_calibrator.sv
// tb_delay_calibrator: directed calibrations with a queue of expected results popped on each Done.
module tb_delay_calibrator;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic [3:0] Channels;
  logic [3:0] Delays [3:0];
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [3:0] MissCnt;

  typedef struct packed {
    logic [15:0] dly;
    logic        err;
    logic [3:0]  miss;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   lastDoneCycle = 0;
  int   lastRise = 0;
  int   cycle = 0;

  delay_calibrator #(.NCHAN(4), .NBITS(4), .LOG2N(3), .MAXMISS(15)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Channels(Channels),
    .Delays(Delays), .Busy(Busy), .Done(Done), .Err(Err), .MissCnt(MissCnt)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkDelays(input string tag, input logic [15:0] expv);
    for (int i = 0; i < 4; i++)
      checkVal($sformatf("%s.Delays[%0d]", tag, i), {28'd0, Delays[i]}, {28'd0, expv[4*i +: 4]});
  endtask

  function automatic exp_t mkExp(input int d0, input int d1, input int d2, input int d3,
                                 input logic e, input int m);
    exp_t r;
    r.dly  = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    r.err  = e;
    r.miss = 4'(m);
    return r;
  endfunction

  // Each Done pops one expected calibration result.
  always begin
    @(posedge Clk);
    #1;
    if (Done === 1'b1) begin
      doneCount++;
      lastDoneCycle = cycle;
      checkVal("pendingExpectation", {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        checkDelays("done", monExp.dly);
        checkVal("done.Err", {31'd0, Err}, {31'd0, monExp.err});
        checkVal("done.MissCnt", {28'd0, MissCnt}, {28'd0, monExp.miss});
        checkVal("done.Busy", {31'd0, Busy}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input int o1, input int o2, input int o3, input logic [3:0] present);
    int off [4];
    off = '{0, o1, o2, o3};
    for (int k = 0; k < 20; k++) begin
      for (int ch = 0; ch < 4; ch++) Channels[ch] = present[ch] && (off[ch] <= k);
      if (k == 0) lastRise = cycle;
      tick();
    end
    Channels = '0;
    tick();
    tick();
  endtask

  task automatic startCal(input string tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checkVal({tag, ".busyAfterStart"}, {31'd0, Busy}, 32'd1);
    checkVal({tag, ".errClearedOnStart"}, {31'd0, Err}, 32'd0);
    checkVal({tag, ".missClearedOnStart"}, {28'd0, MissCnt}, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input int target, input int latency);
    for (int b = 0; b < 100 && doneCount < target; b++) tick();
    checkVal({tag, ".doneCount"}, doneCount, target);
    checkVal({tag, ".doneLatency"}, lastDoneCycle - lastRise, latency);
  endtask

  initial begin
    Rst_n    = 1'b0;
    Start    = 1'b0;
    Channels = '0;
    tick();
    tick();
    checkDelays("reset", 16'h0000);
    checkVal("reset.Busy", {31'd0, Busy}, 32'd0);
    checkVal("reset.Done", {31'd0, Done}, 32'd0);
    checkVal("reset.Err", {31'd0, Err}, 32'd0);
    checkVal("reset.MissCnt", {28'd0, MissCnt}, 32'd0);
    Rst_n = 1'b1;
    tick();

    // Constant skew +2/+5/+0.
    $display("[TB] constant skew");
    expQ.push_back(mkExp(5, 3, 0, 5, 1'b0, 0));
    startCal("skew");
    for (int e = 0; e < 8; e++) applyStimulus(2, 5, 0, 4'b1111);
    checkOutput("skew", 1, 8);

    // Ch1 alternating 2/3 gives acc=20.
    $display("[TB] rounding");
`ifdef DLYCAL_ROUND_EN
    expQ.push_back(mkExp(3, 0, 3, 3, 1'b0, 0));
`else
    expQ.push_back(mkExp(2, 0, 2, 2, 1'b0, 0));
`endif
    startCal("round");
    for (int e = 0; e < 8; e++) applyStimulus((e % 2 == 0) ? 2 : 3, 0, 0, 4'b1111);
    checkOutput("round", 2, 6);

    // Ch2 absent: abort after 15 misses, prior delays retained.
    $display("[TB] missing channel");
`ifdef DLYCAL_ROUND_EN
    expQ.push_back(mkExp(3, 0, 3, 3, 1'b1, 15));
`else
    expQ.push_back(mkExp(2, 0, 2, 2, 1'b1, 15));
`endif
    startCal("miss");
    for (int e = 0; e < 15; e++) applyStimulus(1, 0, 2, 4'b1011);
    checkOutput("miss", 3, 17);
    checkVal("miss.errHeld", {31'd0, Err}, 32'd1);

    // Ch3 absent on three of eleven events.
    $display("[TB] interleaved misses");
    expQ.push_back(mkExp(4, 0, 4, 4, 1'b0, 3));
    startCal("interleave");
    for (int e = 0; e < 11; e++)
      applyStimulus(4, 0, 0, (e == 1 || e == 4 || e == 7) ? 4'b0111 : 4'b1111);
    checkOutput("interleave", 4, 7);

    // Start while busy must be ignored.
    $display("[TB] start while busy");
    expQ.push_back(mkExp(3, 2, 0, 1, 1'b0, 1));
    startCal("busyStart");
    applyStimulus(1, 3, 2, 4'b0111);
    checkVal("busyStart.missBefore", {28'd0, MissCnt}, 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checkVal("busyStart.stillBusy", {31'd0, Busy}, 32'd1);
    checkVal("busyStart.missKept", {28'd0, MissCnt}, 32'd1);
    for (int e = 0; e < 8; e++) applyStimulus(1, 3, 2, 4'b1111);
    checkOutput("busyStart", 5, 6);

    // Reset mid-window after a good calibration.
    $display("[TB] reset mid-window");
    expQ.push_back(mkExp(5, 3, 0, 5, 1'b0, 0));
    startCal("prior");
    for (int e = 0; e < 8; e++) applyStimulus(2, 5, 0, 4'b1111);
    checkOutput("prior", 6, 8);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Channels = 4'b0001;
    tick();
    tick();
    checkVal("midWindow.Busy", {31'd0, Busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    checkDelays("asyncReset", 16'h0000);
    checkVal("asyncReset.Busy", {31'd0, Busy}, 32'd0);
    checkVal("asyncReset.MissCnt", {28'd0, MissCnt}, 32'd0);
    Channels = '0;
    tick();
    Rst_n = 1'b1;
    tick();
    expQ.push_back(mkExp(1, 1, 0, 1, 1'b0, 0));
    startCal("afterReset");
    for (int e = 0; e < 8; e++) applyStimulus(0, 1, 0, 4'b1111);
    checkOutput("afterReset", 7, 4);

    tick();
    checkVal("queueEmpty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_calibrator.md
# delay_calibrator

Measures per-channel arrival skew relative to reference channel 0 and computes the per-channel `Delays` vector that aligns all channels at the input of the delay stage ahead of the coincidence logic. On `Start`, it averages the offset of each channel's rising edge from channel 0's rising edge over 2^LOG2N valid events. It then publishes `Delays[i] = max_avg - avg[i]`, so that the latest channel receives zero added delay. Its output drives the delay stage's `Delays` input directly.

## Interface
- NCHAN, 4: number of input channels; channel 0 is the reference.
- NBITS, 4: width of each delay/offset; measurement window is 2^NBITS-1 cycles.
- LOG2N, 3: log2 of the number of valid events averaged.
- MAXMISS, 15: number of discarded events that aborts calibration.

- Clk  in  1  clock
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle calibration request; ignored while Busy
- Channels  in  NCHAN  raw channel pulses, synchronous to Clk
- Delays  out  NCHAN x NBITS (unpacked [NCHAN-1:0])  computed delays, held between calibrations
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle pulse at end of calibration (success or error)
- Err  out  1  high if last calibration aborted on misses; cleared on accepted Start
- MissCnt  out  NBITS  discarded-event count of the current/last calibration

## Operation
- Edge detect: a one-cycle registered copy of Channels; edge[i] = Channels[i] & ~prev[i].
- States: IDLE, ARM, WINDOW, ACCUM, COMPUTE.
- IDLE: on Start, clear accumulators, event counter, MissCnt and Err; go to ARM.
- ARM: wait for edge[0]. In that cycle, record offset 0 for every channel with an edge and mark it hit; set cnt=1; go to WINDOW. Edges on other channels before edge[0] are ignored.
- WINDOW: for each not-yet-hit channel with an edge, record offset=cnt and mark it hit. Only the first edge per channel counts. edge[0] is ignored. Exit to ACCUM when all channels are hit or cnt==2^NBITS-1 (after sampling that cycle). Otherwise cnt++.
- ACCUM, all hit: add each offset to acc[i] (NBITS+LOG2N bits, no overflow possible); increment the event counter. If it reaches 2^LOG2N, go to COMPUTE; else go to ARM.
- ACCUM, any miss: discard the event and increment MissCnt. If MissCnt reaches MAXMISS, set Err, pulse Done and go to IDLE with Delays unchanged; else go to ARM.
- COMPUTE: avg[i] = acc[i] >> LOG2N, D = max over avg[i]. Register Delays[i] = D - avg[i], pulse Done, go to IDLE. Delays[0] = D.
- Start outside IDLE is ignored. There is no abort input; reset is the only abort.

## Timing
- Reset values: Delays all 0, Busy 0, Done 0, Err 0, MissCnt 0, state IDLE, prev edge register 0.
- Start sampled in IDLE at cycle t: Busy=1 from t+1; first edge is accepted from t+1.
- Edge latency: a Channels rising at cycle t is seen as an edge at t (comparison against prev).
- Event length: ARM cycle, then 1..2^NBITS-1 WINDOW cycles, then 1 ACCUM cycle.
- COMPUTE takes one cycle. Delays, Done=1 and Busy=0 are all visible in the cycle after COMPUTE.
- On an Err abort, Done, Err and Busy=0 are visible in the cycle after the failing ACCUM.
- Reset asserted mid-calibration: all state returns to reset values immediately. Delays returns to 0, not the previous result.
- Channel held high across events produces no new edge and counts as a miss for that event.

## Configuration
- DLYCAL_ROUND_EN defined: avg[i] = (acc[i] + 2^(LOG2N-1)) >> LOG2N, i.e. round half up. The result is ≤ 2^NBITS-1 because each offset is ≤ 2^NBITS-1.
- Undefined: avg[i] = acc[i] >> LOG2N (truncate).

## Test plan
- Constant skew, NCHAN=4/NBITS=4/LOG2N=3. Channels 1, 2, 3 edges at +2, +5, +0 after ch0 for 8 events -> Done pulse; Delays = {5,3,0,5} for ch0..ch3; Err=0; MissCnt=0.
- Rounding. Ch1 offsets alternate 2,3 (acc=20), others +0 -> without DLYCAL_ROUND_EN avg1=2, Delays={2,0,2,2}. With it, avg1=3, Delays={3,0,3,3}.
- Missing channel. Ch2 never pulses, MAXMISS=15 -> after 15 events Done and Err=1; MissCnt=15; Delays keep the prior values.
- Interleaved misses. Ch3 absent on 3 of 11 events, ch1 always at +4 -> Done after 11 events; MissCnt=3; Delays={4,0,4,4}.
- Start while Busy, mid-calibration -> ignored; counters untouched; single Done at the normal time.
- Reset mid-WINDOW after a prior calibration produced {5,3,0,5} -> Delays={0,0,0,0}, Busy=0. A subsequent Start calibrates from scratch.
